// File: rtl/fir_mac_scheduler.sv
// fir_mac_scheduler: time-multiplexed FIR controller.
// A circular delay line and a loadable coefficient table feed one shared
// multiply-accumulate unit that walks all taps, one tap per clock. The
// finished sum is held on a valid/ready output until it is accepted.
module fir_mac_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NUM_TAPS   = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                coef_wr_en,
  input  logic        [$clog2(NUM_TAPS)-1:0]  coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0]        coef_wr_data,
  output logic signed [ACC_WIDTH-1:0]         out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  localparam int PTR_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam logic [PTR_W:0]   TAPS = (PTR_W + 1)'(NUM_TAPS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_TAPS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              newest_q, newest_d;
  logic [PTR_W-1:0]              k_q, k_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]   out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0]  x_buf_q [NUM_TAPS];
  logic signed [DATA_WIDTH-1:0]  x_buf_d [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]  c_q     [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0]  c_d     [NUM_TAPS];

  logic [PTR_W-1:0]              rd_idx;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_WIDTH-1:0]   acc_sum;
  logic                          coef_wr_ok;

  // Full-precision product widened to the accumulator without loss.
  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_WIDTH - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Delay-line slot holding x[n-k]; wraps modulo NUM_TAPS, so the
  // tap count does not have to be a power of two.
  function automatic logic [PTR_W-1:0] tap_index(input logic [PTR_W-1:0] newest,
                                                 input logic [PTR_W-1:0] k);
    logic [PTR_W:0] s;
    s = {1'b0, newest} + TAPS - {1'b0, k};
    if (s >= TAPS) s = s - TAPS;
    return s[PTR_W-1:0];
  endfunction

  assign rd_idx   = tap_index(newest_q, k_q);
  assign prod     = x_buf_q[rd_idx] * c_q[k_q];
  assign acc_sum  = acc_q + sext_prod(prod);

  assign in_ready  = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  // Table updates are blocked while taps are being summed so one result
  // never mixes two coefficient sets.
  assign coef_wr_ok = coef_wr_en && ({1'b0, coef_wr_addr} < TAPS) && (state_q != MAC);

  // Next-state logic: sample capture, tap sequencing and result handshake.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    newest_d    = newest_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    x_buf_d     = x_buf_q;
    c_d         = c_q;

    if (coef_wr_ok) c_d[coef_wr_addr] = coef_wr_data;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_buf_d[wr_ptr_q] = in_data;
          newest_d          = wr_ptr_q;
          wr_ptr_d          = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
          acc_d             = '0;
          k_d               = '0;
          state_d           = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + 1'b1;
        if (k_q == LAST) begin
          k_d         = '0;
          out_data_d  = acc_sum;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset also clears the delay line and coefficient table.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      newest_q    <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        x_buf_q[i] <= '0;
        c_q[i]     <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      newest_q    <= newest_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      x_buf_q     <= x_buf_d;
      c_q         <= c_d;
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_fir_mac_scheduler;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = DW + CW + $clog2(N);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 coef_wr_en = 1'b0;
  logic [2:0]           coef_wr_addr = '0;
  logic signed [CW-1:0] coef_wr_data = '0;
  logic signed [AW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 busy;

  int n_chk  = 0;
  int n_fail = 0;

  fir_mac_scheduler #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(N)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_data(coef_wr_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[0] is the newest sample; a result is the dot product of the
  // coefficient table with the history, delivered N cycles after acceptance.
  longint m_hist [N];
  longint m_c    [N];
  longint m_y, m_out;
  int     m_cnt;
  bit     m_hold, m_valid, m_live;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_hist[i] = 0; m_c[i] = 0; end
      m_cnt = 0; m_hold = 0; m_valid = 0; m_out = 0; m_y = 0; m_live = 1;
    end else if (m_live) begin
      if (m_cnt == 0 && !m_hold) begin
        if (coef_wr_en && int'(coef_wr_addr) < N) m_c[coef_wr_addr] = coef_wr_data;
        if (in_valid) begin
          for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = in_data;
          m_y = 0;
          for (int i = 0; i < N; i++) m_y += m_c[i] * m_hist[i];
          m_cnt = N;
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin m_out = m_y; m_valid = 1; m_hold = 1; end
      end else begin
        if (coef_wr_en && int'(coef_wr_addr) < N) m_c[coef_wr_addr] = coef_wr_data;
        if (out_ready) begin m_valid = 0; m_hold = 0; end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      chk("in_ready",  in_ready,  !reset && m_cnt == 0 && !m_hold);
      chk("busy",      busy,      m_cnt != 0 || m_hold);
      chk("out_valid", out_valid, m_valid);
      chk("out_data",  out_data,  m_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 0; out_ready = 0; coef_wr_en = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_coefs(input int base, input int step);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      coef_wr_en = 1; coef_wr_addr = 3'(k); coef_wr_data = 16'(base + step * k);
    end
    @(negedge clk);
    coef_wr_en = 0;
  endtask

  task automatic wait_in_ready();
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("out_valid_timeout", 0, 1);
  endtask

  // Send one sample, optionally stall in HOLD while pulsing in_valid, then
  // take the result.
  task automatic xact(input logic signed [DW-1:0] s, input int hold,
                      output logic signed [63:0] y);
    @(negedge clk);
    wait_in_ready();
    in_valid = 1; in_data = s;
    @(negedge clk);
    in_valid = 0;
    wait_out_valid();
    repeat (hold) begin
      in_valid = 1; in_data = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 0;
    y = out_data;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic signed [63:0] y;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_busy",      busy,      0);
    reset = 1'b0;

    // Impulse through c = 1..8.
    load_coefs(1, 1);
    for (int i = 0; i < N; i++) begin
      xact((i == 0) ? 16'sd1 : 16'sd0, 0, y);
      chk("impulse", y, i + 1);
    end

    // Step of 100 through unity taps.
    do_reset();
    load_coefs(1, 0);
    for (int i = 0; i < N + 1; i++) begin
      xact(16'sd100, 0, y);
      chk("step", y, 100 * ((i < N) ? i + 1 : N));
    end

    // Most negative sample and coefficient.
    do_reset();
    load_coefs(-32768, 0);
    for (int i = 0; i < N; i++) xact(-16'sd32768, 0, y);
    chk("extreme", y, 64'sd8589934592);

    // Stall in HOLD for 5 cycles with in_valid pulses that must be dropped.
    xact(16'sd0, 5, y);
    chk("hold_result", y, 64'sd7516192768);
    xact(16'sd0, 0, y);
    chk("hold_no_consume", y, 64'sd6442450944);

    // Coefficient writes during MAC are ignored.
    do_reset();
    load_coefs(1, 1);
    @(negedge clk);
    wait_in_ready();
    in_valid = 1; in_data = 16'sd1;
    @(negedge clk);
    in_valid = 0; coef_wr_en = 1; coef_wr_addr = 3'd0; coef_wr_data = 16'sd5;
    @(negedge clk);
    coef_wr_addr = 3'd1; coef_wr_data = 16'sd100;
    @(negedge clk);
    coef_wr_en = 0;
    wait_out_valid();
    chk("mac_wr_result", out_data, 1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    xact(16'sd2, 0, y);
    chk("mac_wr_table", y, 4);

    // Reset in the middle of MAC aborts and clears buffer and table.
    @(negedge clk);
    wait_in_ready();
    in_valid = 1; in_data = 16'sd7;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready",  in_ready,  0);
    @(negedge clk);
    reset = 0;
    load_coefs(1, 1);
    xact(16'sd1, 0, y);
    chk("midrst_impulse", y, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset        = ($urandom_range(0, 499) == 0);
      in_valid     = $urandom_range(0, 1);
      in_data      = 16'($urandom);
      out_ready    = ($urandom_range(0, 2) != 0);
      coef_wr_en   = ($urandom_range(0, 4) == 0);
      coef_wr_addr = 3'($urandom);
      coef_wr_data = 16'($urandom);
    end
    @(negedge clk);
    reset = 0; in_valid = 0; coef_wr_en = 0; out_ready = 1;
    repeat (N + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
